// File: rtl/riscv_pkg.sv
// Shared encodings and types for the memory stage: WB result-source codes,
// the memory-access FSM state type and the watchdog limit.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  localparam int unsigned TIMEOUT_CYCLES = 16;

  // Code 11 is unused and behaves like an ALU result.
  function automatic logic [1:0] norm_src(input logic [1:0] src);
    return (src == 2'b11) ? RES_ALU : src;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the data memory (slave).
interface memory_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_wdog.sv
// Memory-access watchdog: counts WAIT cycles from 1 and flags a timeout when
// the count reaches TIMEOUT_CYCLES without an ack. Built only with MEM_TIMEOUT_EN.
`ifdef MEM_TIMEOUT_EN
module mem_wdog
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_wait,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  assign o_timeout = i_wait && (r_cnt == CW'(TIMEOUT_CYCLES)) && !i_ack;

  // Wait-cycle counter; cleared whenever the access completes or is not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= CW'(1);
    end else if (i_wait && !i_ack && !o_timeout) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule
`endif

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues loads/stores on the data-memory bus, stalls
// the front of the pipe until ack, and holds the MEM/WB register.
// Optional watchdog compiled in with MEM_TIMEOUT_EN.
module memory_stage
  import riscv_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           reg_wrM,
  input  logic           mem_wrM,
  input  logic [1:0]     result_srcM,
  input  logic [31:0]    ALU_resultM,
  input  logic [31:0]    wr_dataM,
  input  logic [31:0]    PCp4M,
  input  logic [4:0]     rdM,
  memory_stage_if.master dmem,
  output logic           stallM,
  output logic           reg_wrW,
  output logic [1:0]     result_srcW,
  output logic [31:0]    ALU_resultW,
  output logic [31:0]    read_dataW,
  output logic [31:0]    PCp4W,
  output logic [4:0]     rdW,
  output logic           bus_errW
);

  mem_state_t r_state;
  mem_state_t w_state_nxt;
  logic       w_mem_op;
  logic       w_is_load;
  logic       w_req;
  logic       w_req_g;
  logic       w_done;
  logic       w_cmpl;
  logic       w_timeout;

  logic        r_reg_wr;
  logic [1:0]  r_result_src;
  logic [31:0] r_alu_result;
  logic [31:0] r_read_data;
  logic [31:0] r_pcp4;
  logic [4:0]  r_rd;
  logic        r_bus_err;

  assign w_mem_op  = (result_srcM == RES_MEM) | mem_wrM;
  assign w_is_load = (result_srcM == RES_MEM) & ~mem_wrM;

`ifdef MEM_TIMEOUT_EN
  mem_wdog u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   ((r_state == S_IDLE) && w_req && !w_done),
    .i_wait    (r_state == S_WAIT),
    .i_ack     (dmem.dmem_ack),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = dmem.dmem_ack | w_timeout;

  // FSM next-state and raw request.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = w_mem_op;
        if (w_mem_op && !w_done) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req       = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Gating with rst_n drops the request the moment reset asserts.
  assign w_req_g         = w_req & rst_n;
  assign w_cmpl          = w_req_g & w_done;
  assign stallM          = w_req_g & ~w_done;
  assign dmem.dmem_req   = w_req_g;
  assign dmem.dmem_we    = w_req_g & mem_wrM;
  assign dmem.dmem_addr  = {ALU_resultM[31:2], 2'b00};
  assign dmem.dmem_wdata = wr_dataM;

  // MEM/WB register: bubble while stalled, otherwise capture the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_wr     <= 1'b0;
      r_result_src <= 2'b00;
      r_alu_result <= 32'h0000_0000;
      r_read_data  <= 32'h0000_0000;
      r_pcp4       <= 32'h0000_0000;
      r_rd         <= 5'd0;
      r_bus_err    <= 1'b0;
    end else if (stallM) begin
      r_reg_wr     <= 1'b0;
      r_result_src <= RES_ALU;
      r_alu_result <= ALU_resultM;
      r_read_data  <= 32'h0000_0000;
      r_pcp4       <= PCp4M;
      r_rd         <= 5'd0;
      r_bus_err    <= 1'b0;
    end else begin
      r_reg_wr     <= reg_wrM;
      r_result_src <= norm_src(result_srcM);
      r_alu_result <= ALU_resultM;
      r_read_data  <= (w_cmpl && w_is_load && dmem.dmem_ack) ? dmem.dmem_rdata : 32'h0000_0000;
      r_pcp4       <= PCp4M;
      r_rd         <= rdM;
      r_bus_err    <= w_timeout;
    end
  end

  assign reg_wrW     = r_reg_wr;
  assign result_srcW = r_result_src;
  assign ALU_resultW = r_alu_result;
  assign read_dataW  = r_read_data;
  assign PCp4W       = r_pcp4;
  assign rdW         = r_rd;
  assign bus_errW    = r_bus_err;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: zero-wait, multi-cycle, reset-in-wait,
// back-to-back and watchdog (MEM_TIMEOUT_EN) scenarios.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_wrM, mem_wrM;
  logic [1:0]  result_srcM;
  logic [31:0] ALU_resultM, wr_dataM, PCp4M;
  logic [4:0]  rdM;
  logic        stallM, reg_wrW, bus_errW;
  logic [1:0]  result_srcW;
  logic [31:0] ALU_resultW, read_dataW, PCp4W;
  logic [4:0]  rdW;
  int          total = 0;
  int          bad = 0;
  int          cnt;

  memory_stage_if dmem_bus ();

  memory_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_wrM     (reg_wrM),
    .mem_wrM     (mem_wrM),
    .result_srcM (result_srcM),
    .ALU_resultM (ALU_resultM),
    .wr_dataM    (wr_dataM),
    .PCp4M       (PCp4M),
    .rdM         (rdM),
    .dmem        (dmem_bus),
    .stallM      (stallM),
    .reg_wrW     (reg_wrW),
    .result_srcW (result_srcW),
    .ALU_resultW (ALU_resultW),
    .read_dataW  (read_dataW),
    .PCp4W       (PCp4W),
    .rdW         (rdW),
    .bus_errW    (bus_errW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rw, input logic mw, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [31:0] pc, input logic [4:0] rd);
    reg_wrM = rw; mem_wrM = mw; result_srcM = src;
    ALU_resultM = alu; wr_dataM = wd; PCp4M = pc; rdM = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    #12;
    check("rst_req", dmem_bus.dmem_req, 32'd0);
    check("rst_stall", stallM, 32'd0);
    check("rst_regwr", reg_wrW, 32'd0);
    check("rst_rd", rdW, 32'd0);
    check("rst_rdata", read_dataW, 32'd0);
    check("rst_buserr", bus_errW, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU op with a stray ack that must be ignored
    set_op(1'b1, 1'b0, 2'b00, 32'h55, 32'h0, 32'h104, 5'd3);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h99;
    #1;
    check("alu_req", dmem_bus.dmem_req, 32'd0);
    check("alu_stall", stallM, 32'd0);
    tick();
    check("alu_regwr", reg_wrW, 32'd1);
    check("alu_rd", rdW, 32'd3);
    check("alu_res", ALU_resultW, 32'h55);
    check("alu_rdata", read_dataW, 32'd0);
    check("alu_pc4", PCp4W, 32'h104);

    // Zero-wait load
    set_op(1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 32'h108, 5'd5);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hDEADBEEF;
    #1;
    check("zw_req", dmem_bus.dmem_req, 32'd1);
    check("zw_we", dmem_bus.dmem_we, 32'd0);
    check("zw_addr", dmem_bus.dmem_addr, 32'h100);
    check("zw_stall", stallM, 32'd0);
    tick();
    check("zw_rdata", read_dataW, 32'hDEADBEEF);
    check("zw_regwr", reg_wrW, 32'd1);
    check("zw_rd", rdW, 32'd5);
    check("zw_src", result_srcW, 32'd1);

    // Back-to-back ALU op right behind the load
    set_op(1'b1, 1'b0, 2'b00, 32'h77, 32'h0, 32'h10C, 5'd7);
    dmem_bus.dmem_ack = 1'b0;
    #1;
    check("b2b_stall", stallM, 32'd0);
    tick();
    check("b2b_rd", rdW, 32'd7);
    check("b2b_res", ALU_resultW, 32'h77);
    check("b2b_rdata", read_dataW, 32'd0);

    // Store with ack on the third cycle
    set_op(1'b0, 1'b1, 2'b00, 32'h203, 32'h1234, 32'h110, 5'd9);
    #1;
    check("st_req1", dmem_bus.dmem_req, 32'd1);
    check("st_we1", dmem_bus.dmem_we, 32'd1);
    check("st_addr1", dmem_bus.dmem_addr, 32'h200);
    check("st_wdata1", dmem_bus.dmem_wdata, 32'h1234);
    check("st_stall1", stallM, 32'd1);
    tick();
    check("st_bub1_rd", rdW, 32'd0);
    check("st_bub1_regwr", reg_wrW, 32'd0);
    check("st_req2", dmem_bus.dmem_req, 32'd1);
    check("st_addr2", dmem_bus.dmem_addr, 32'h200);
    check("st_stall2", stallM, 32'd1);
    tick();
    check("st_bub2_rd", rdW, 32'd0);
    dmem_bus.dmem_ack = 1'b1;
    #1;
    check("st_req3", dmem_bus.dmem_req, 32'd1);
    check("st_we3", dmem_bus.dmem_we, 32'd1);
    check("st_stall3", stallM, 32'd0);
    tick();
    check("st_wb_rd", rdW, 32'd9);
    check("st_wb_regwr", reg_wrW, 32'd0);
    check("st_wb_rdata", read_dataW, 32'd0);
    check("st_wb_res", ALU_resultW, 32'h203);
    dmem_bus.dmem_ack = 1'b0;

    // Reset asserted in the second WAIT cycle
    set_op(1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 32'h114, 5'd4);
    #1;
    check("rw_stall", stallM, 32'd1);
    tick();
    tick();
    check("rw_pre_res", ALU_resultW, 32'h300);
    rst_n = 1'b0;
    #1;
    check("rw_req", dmem_bus.dmem_req, 32'd0);
    check("rw_stall0", stallM, 32'd0);
    check("rw_res", ALU_resultW, 32'd0);
    check("rw_pc4", PCp4W, 32'd0);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hCAFE0001;
    rst_n = 1'b1;
    #1;
    check("rw_post_req", dmem_bus.dmem_req, 32'd1);
    check("rw_post_stall", stallM, 32'd0);
    tick();
    check("rw_post_rdata", read_dataW, 32'hCAFE0001);
    check("rw_post_rd", rdW, 32'd4);
    dmem_bus.dmem_ack = 1'b0;

    // Result-source codes 11 and 10
    set_op(1'b1, 1'b0, 2'b11, 32'h44, 32'h0, 32'h200, 5'd2);
    #1;
    check("s11_req", dmem_bus.dmem_req, 32'd0);
    tick();
    check("s11_src", result_srcW, 32'd0);
    check("s11_rd", rdW, 32'd2);
    set_op(1'b1, 1'b0, 2'b10, 32'h45, 32'h0, 32'h204, 5'd1);
    tick();
    check("s10_src", result_srcW, 32'd2);
    check("s10_pc4", PCp4W, 32'h204);

    // Load and store flags together: store wins
    set_op(1'b1, 1'b1, 2'b01, 32'h400, 32'hAB, 32'h208, 5'd8);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hFFFF;
    #1;
    check("ls_we", dmem_bus.dmem_we, 32'd1);
    tick();
    check("ls_rdata", read_dataW, 32'd0);

    // Long wait without ack
    dmem_bus.dmem_ack = 1'b0;
    set_op(1'b1, 1'b0, 2'b01, 32'h500, 32'h0, 32'h20C, 5'd6);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stallM) break;
      cnt++;
      tick();
    end
`ifdef MEM_TIMEOUT_EN
    check("to_stall_cycles", cnt, 32'd16);
    check("to_req", dmem_bus.dmem_req, 32'd1);
    tick();
    check("to_rdata", read_dataW, 32'd0);
    check("to_buserr", bus_errW, 32'd1);
    check("to_rd", rdW, 32'd6);
    set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h210, 5'd0);
    tick();
    check("to_buserr_drop", bus_errW, 32'd0);
    set_op(1'b1, 1'b0, 2'b01, 32'h600, 32'h0, 32'h214, 5'd10);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h1111;
    #1;
    check("to_next_req", dmem_bus.dmem_req, 32'd1);
    check("to_next_stall", stallM, 32'd0);
    tick();
    check("to_next_rdata", read_dataW, 32'h1111);
    dmem_bus.dmem_ack = 1'b0;
    set_op(1'b1, 1'b0, 2'b01, 32'h700, 32'h0, 32'h218, 5'd11);
    repeat (16) tick();
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'hA5A5A5A5;
    #1;
    check("at_stall", stallM, 32'd0);
    tick();
    check("at_rdata", read_dataW, 32'hA5A5A5A5);
    check("at_buserr", bus_errW, 32'd0);
`else
    check("nw_stall_cycles", cnt, 32'd40);
    check("nw_buserr", bus_errW, 32'd0);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 32'h600D;
    #1;
    check("nw_stall", stallM, 32'd0);
    tick();
    check("nw_rdata", read_dataW, 32'h600D);
    check("nw_rd", rdW, 32'd6);
    check("nw_buserr2", bus_errW, 32'd0);
`endif
    dmem_bus.dmem_ack = 1'b0;
    set_op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: reg_wrM, mem_wrM  input  1 each  EX/MEM register-write and store controls.
REQ-005 Port: result_srcM  input  2  00 ALU, 01 load, 10 PC+4; 11 is treated as 00.
REQ-006 Port: ALU_resultM, wr_dataM, PCp4M  input  32 each  address/result, store data, PC+4.
REQ-007 Port: rdM  input  5  destination register.
REQ-008 Port: dmem_req, dmem_we  output  1 each  data-memory request and write strobe.
REQ-009 Port: dmem_addr, dmem_wdata  output  32 each  word address (bits [1:0] forced 0) and store data.
REQ-010 Port: dmem_ack  input  1  access complete; dmem_rdata input 32, valid with ack.
REQ-011 Port: stallM  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers while high.
REQ-012 Port: reg_wrW, result_srcW[2], ALU_resultW[32], read_dataW[32], PCp4W[32], rdW[5], bus_errW[1]  outputs  MEM/WB register.

Function
REQ-013 A memory op SHALL be result_srcM==01 (load) or mem_wrM==1 (store); store wins if both.
REQ-014 FSM states SHALL be IDLE and WAIT.
REQ-015 In IDLE with a memory op, dmem_req SHALL assert combinationally in the same cycle; dmem_we=mem_wrM.
REQ-016 IDLE with ack in the same cycle: zero-wait; stallM stays 0; MEM/WB captures on the next edge; remain IDLE.
REQ-017 IDLE without ack: stallM=1; go to WAIT on the next edge.
REQ-018 In WAIT, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay asserted and stable until ack.
REQ-019 stallM SHALL equal dmem_req AND NOT dmem_ack (NOT completion when timeout is enabled), purely combinational.
REQ-020 WAIT with ack: stallM=0 in that cycle; MEM/WB captures on the next edge; FSM returns to IDLE.
REQ-021 Completing a load SHALL register read_dataW<=dmem_rdata; a store or non-memory op SHALL register read_dataW<=0.
REQ-022 While stallM=1, each edge SHALL load a bubble into MEM/WB: reg_wrW=0, rdW=0, result_srcW=00, bus_errW=0.
REQ-023 A non-memory op SHALL pass to MEM/WB in one cycle with no request.
REQ-024 dmem_ack while no request is outstanding SHALL be ignored.

Reset
REQ-025 Asserting rst_n low SHALL asynchronously force IDLE, clear the timeout counter and set every registered output to 0.
REQ-026 Reset mid-WAIT SHALL drop dmem_req immediately, with no completion and no MEM/WB update.
REQ-027 After reset deasserts, the first edge SHALL sample normally.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN SHALL compile in a watchdog with localparam TIMEOUT_CYCLES=16.
REQ-029 With the macro, the counter SHALL count WAIT cycles from 1, with a timeout event when it reaches TIMEOUT_CYCLES and ack is low.
REQ-030 On a timeout event, completion SHALL occur as if acked with rdata=0, bus_errW=1 for one cycle, and return to IDLE.
REQ-031 Ack and timeout in the same cycle SHALL be treated as ack, with bus_errW=0.
REQ-032 Without the macro, the module SHALL wait indefinitely and tie bus_errW to 0.

Structure
REQ-033 Package riscv_pkg SHALL hold the RES_ALU/RES_MEM/RES_PC4 encodings, the mem_state_t enum and the TIMEOUT_CYCLES default.
REQ-034 Sub-module mem_wdog (counter plus timeout compare) SHALL exist only under MEM_TIMEOUT_EN.

Verification
REQ-035 Zero-wait case: load at addr 0x100 with ack in the same cycle and rdata 0xDEADBEEF -> stallM never high; next edge read_dataW=0xDEADBEEF, reg_wrW=1.
REQ-036 3-cycle wait case: store of 0x1234 to 0x203 with ack on cycle 3 -> dmem_addr=0x200 stable; stallM high 2 cycles; 2 bubbles, then store in WB with reg_wrW=0.
REQ-037 Reset-in-WAIT case: rst_n low in the second WAIT cycle -> dmem_req=0 at once; all outputs 0; IDLE.
REQ-038 Timeout case (MEM_TIMEOUT_EN, no ack): 16 stall cycles -> read_dataW=0, bus_errW=1 for 1 cycle; the next op issues normally.
REQ-039 Ack-on-timeout case: ack on the timeout cycle -> bus_errW=0 and rdata is captured.
REQ-040 Back-to-back case: ALU op after a load -> ALU op reaches WB one cycle after the load, with no extra bubble.
